// File: rtl/o_serializer_pkg.sv
// Shared types and limits for the output serializer.
// Holds the FSM state enum, legal WIDTH range and the bit-counter type.
package o_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 10;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int CNT_W = clog2(WIDTH_MAX);

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/o_serializer_if.sv
// Word handshake between fabric (master) and serializer (slave).
// D: parallel word, DATA_VALID: word present, DATA_READY: slot free.
interface o_serializer_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] D;
  logic             DATA_VALID;
  logic             DATA_READY;

  modport master (
    output D,
    output DATA_VALID,
    input  DATA_READY
  );

  modport slave (
    input  D,
    input  DATA_VALID,
    output DATA_READY
  );

endinterface

// File: rtl/o_serializer_shift.sv
// Load/shift register feeding the serial output; shifts toward the output end.
// Ports: C/R/E clock-reset-enable, i_load/i_shift/i_data control, o_head next bit.
module o_serializer_shift
  import o_serializer_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_VALUE = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_head
);

  logic [WIDTH-1:0] r_sr;

  // The first bit goes straight to Q on a load, so the register
  // keeps only the bits still to come.
  function automatic logic [WIDTH-1:0] shift_once(
    input logic [WIDTH-1:0] x
  );
    if (MSB_FIRST)
      return {x[WIDTH-2:0], IDLE_VALUE};
    else
      return {IDLE_VALUE, x[WIDTH-1:1]};
  endfunction

  always_ff @(posedge C) begin
    if (R) begin
      r_sr <= {WIDTH{IDLE_VALUE}};
    end else if (E) begin
      if (i_load)
        r_sr <= shift_once(i_data);
      else if (i_shift)
        r_sr <= shift_once(r_sr);
    end
  end

  assign o_head = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];

endmodule

// File: rtl/o_serializer.sv
// Parallel-to-serial output serializer with one-word holding register.
// Ports: C/R/E, s (word handshake), Q serial out, FRAME first bit, BUSY.
module o_serializer
  import o_serializer_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_VALUE = 1'b0
) (
  input  logic           C,
  input  logic           R,
  input  logic           E,
  o_serializer_if.slave  s,
  output logic           Q,
  output logic           FRAME,
  output logic           BUSY
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("o_serializer: WIDTH must be 3..10");
  end

  localparam cnt_t LAST = cnt_t'(WIDTH - 1);

  state_e           r_state;
  cnt_t             r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             r_q;
  logic             r_frame;
  logic             r_busy;

  logic w_run;
  logic w_ready;
  logic w_accept;
  logic w_at_end;
  logic w_load;
  logic w_shift;
  logic w_drain;
  logic w_first;
  logic w_head;

  assign w_run    = E & ~R;
  assign w_ready  = w_run & ~r_hold_full;
  assign w_accept = w_ready & s.DATA_VALID;
  assign w_at_end = (r_state == ST_SHIFT) & (r_cnt == LAST);

  // Exactly one of load/shift/drain fires on an enabled edge
  // unless the block sits idle with nothing held.
  assign w_load  = w_run & r_hold_full &
                   ((r_state == ST_IDLE) | w_at_end);
  assign w_shift = w_run & (r_state == ST_SHIFT) & ~w_at_end;
  assign w_drain = w_run & w_at_end & ~r_hold_full;

  assign w_first = MSB_FIRST ? r_hold[WIDTH-1] : r_hold[0];

  assign s.DATA_READY = w_ready;

  always_ff @(posedge C) begin
    if (R) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (E) begin
      if (w_accept)
        r_hold <= s.D;
      r_hold_full <= w_accept | (r_hold_full & ~w_load);
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_q     <= IDLE_VALUE;
      r_frame <= 1'b0;
      r_busy  <= 1'b0;
    end else if (E) begin
      unique case (1'b1)
        w_load: begin
          r_state <= ST_SHIFT;
          r_cnt   <= '0;
          r_q     <= w_first;
          r_frame <= 1'b1;
          r_busy  <= 1'b1;
        end
        w_shift: begin
          r_cnt   <= r_cnt + cnt_t'(1);
          r_q     <= w_head;
          r_frame <= 1'b0;
        end
        w_drain: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_q     <= IDLE_VALUE;
          r_frame <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_frame <= 1'b0;
        end
      endcase
    end
  end

  o_serializer_shift #(
    .WIDTH      (WIDTH),
    .MSB_FIRST  (MSB_FIRST),
    .IDLE_VALUE (IDLE_VALUE)
  ) u_shift (
    .C       (C),
    .R       (R),
    .E       (E),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (r_hold),
    .o_head  (w_head)
  );

  assign Q     = r_q;
  assign FRAME = r_frame;
  assign BUSY  = r_busy;

endmodule
